// File: rtl/bits_arbiter_if.sv
// Requester/consumer bus for bits_arbiter: request and operand bits in,
// one-hot grant and the tagged result with its valid/ready handshake out.
interface bits_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] A;
    logic [NREQ-1:0] B;
    logic [NREQ-1:0] GNT;
    logic            VALID;
    logic            RES_READY;
    logic [7:0]      RES;
    logic [3:0]      RES_Z;
    logic [IDW-1:0]  RES_ID;
    logic [7:0]      DONE_CNT;

    modport slave (
        input  REQ, A, B, RES_READY,
        output GNT, VALID, RES, RES_Z, RES_ID, DONE_CNT
    );

    modport master (
        output REQ, A, B, RES_READY,
        input  GNT, VALID, RES, RES_Z, RES_ID, DONE_CNT
    );
endinterface

// File: rtl/bits_arbiter.sv
// Round-robin sharing of one z = A + B + 3, RES = z * 17 datapath among NREQ
// requesters, with a tagged result held under a valid/ready handshake.
module bits_arbiter #(
    parameter int NREQ = 4
) (
    input  logic          CLK,
    input  logic          RST,
    bits_arbiter_if.slave io_bus
);
    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic            r_a;
    logic            r_b;
    logic [NREQ-1:0] r_gnt;
    logic            r_valid;
    logic [7:0]      r_res;
    logic [3:0]      r_resZ;
    logic [IDW-1:0]  r_resId;
    logic [7:0]      r_doneCnt;

    logic [IDW-1:0]  w_cand;
    logic [IDW-1:0]  w_win;
    logic            w_any;
    logic [IDW-1:0]  w_ptrNext;
    logic [3:0]      w_z;
    logic [7:0]      w_res;

    // Search order starts at the pointer and wraps; the first requester found wins.
    always_comb begin
        w_cand = '0;
        w_win  = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_any && io_bus.REQ[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_ptrNext = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_z       = {3'b000, r_a} + {3'b000, r_b} + 4'd3;
    assign w_res     = {4'b0000, w_z} * 8'd17;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_gnt     <= '0;
            r_valid   <= 1'b0;
            r_res     <= '0;
            r_resZ    <= '0;
            r_resId   <= '0;
            r_doneCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= io_bus.A[w_win];
                        r_b     <= io_bus.B[w_win];
                        r_id    <= w_win;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_ptr   <= w_ptrNext;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_resZ  <= w_z;
                    r_res   <= w_res;
                    r_resId <= r_id;
                    r_valid <= 1'b1;
                    r_gnt   <= '0;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    // Result stays frozen until the consumer takes it.
                    if (io_bus.RES_READY) begin
                        r_valid   <= 1'b0;
                        r_doneCnt <= r_doneCnt + 8'd1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.GNT      = r_gnt;
    assign io_bus.VALID    = r_valid;
    assign io_bus.RES      = r_res;
    assign io_bus.RES_Z    = r_resZ;
    assign io_bus.RES_ID   = r_resId;
    assign io_bus.DONE_CNT = r_doneCnt;
endmodule

// File: tb/tb_bits_arbiter.sv
// Scoreboard bench for bits_arbiter: stimulus queues expected grants/results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_bits_arbiter;
    localparam int NREQ = 4;

    typedef struct {
        int id;
        int z;
        int res;
    } resExp_t;

    logic CLK = 1'b0;
    logic RST;

    bits_arbiter_if #(.NREQ(NREQ)) bus ();

    bits_arbiter #(.NREQ(NREQ)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus)
    );

    always #5 CLK = ~CLK;

    int            checks = 0;
    int            errors = 0;
    int            expGntQ[$];
    resExp_t       expResQ[$];
    int            gntId;
    resExp_t       popped;
    logic [7:0]    expDone;
    logic [NREQ-1:0] prevGnt = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] a,
                                 input logic [NREQ-1:0] b);
        bus.REQ = req;
        bus.A   = a;
        bus.B   = b;
    endtask

    task automatic checkResetState();
        checkOutput("rst_gnt", 32'(bus.GNT), 0);
        checkOutput("rst_valid", 32'(bus.VALID), 0);
        checkOutput("rst_res", 32'(bus.RES), 0);
        checkOutput("rst_res_z", 32'(bus.RES_Z), 0);
        checkOutput("rst_res_id", 32'(bus.RES_ID), 0);
        checkOutput("rst_done_cnt", 32'(bus.DONE_CNT), 0);
    endtask

    task automatic waitAccept();
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge CLK);
            if (bus.VALID === 1'b1 && bus.RES_READY === 1'b1) seen = 1'b1;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL accept_timeout actual=no_handshake expected=handshake_within_20");
        end
    endtask

    task automatic acceptAndCount();
        waitAccept();
        @(posedge CLK); #1;
        expDone = expDone + 8'd1;
        checkOutput("done_cnt", 32'(bus.DONE_CNT), 32'(expDone));
    endtask

    // Caller is positioned just after a rising edge with the arbiter idle.
    task automatic runTxn(input logic [NREQ-1:0] req, input logic [NREQ-1:0] a,
                          input logic [NREQ-1:0] b, input int win, input int z, input int res);
        expGntQ.push_back(win);
        expResQ.push_back('{win, z, res});
        applyStimulus(req, a, b);
        @(posedge CLK); #1;
        bus.REQ = '0;
        acceptAndCount();
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (bus.GNT !== '0) begin
                if (expGntQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_gnt actual=%b expected=none", bus.GNT);
                end else begin
                    gntId = expGntQ.pop_front();
                    checkOutput("gnt", 32'(bus.GNT), 32'(1) << gntId);
                end
                checkOutput("gnt_pulse", 32'(prevGnt), 0);
            end
            if (bus.VALID === 1'b1 && bus.RES_READY === 1'b1) begin
                if (expResQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result actual=id%0d expected=none", bus.RES_ID);
                end else begin
                    popped = expResQ.pop_front();
                    checkOutput("res", 32'(bus.RES), 32'(popped.res));
                    checkOutput("res_z", 32'(bus.RES_Z), 32'(popped.z));
                    checkOutput("res_id", 32'(bus.RES_ID), 32'(popped.id));
                end
            end
        end
        prevGnt = bus.GNT;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        RST = 1'b1;
        bus.RES_READY = 1'b0;
        applyStimulus('0, '0, '0);
        expDone = '0;
        repeat (3) @(posedge CLK);
        #1;
        checkResetState();
        RST = 1'b0;
        bus.RES_READY = 1'b1;

        $display("[TB] single request and operand sweep");
        runTxn(4'b0100, 4'b0100, 4'b0100, 2, 5, 85);
        runTxn(4'b0001, 4'b0000, 4'b0000, 0, 3, 51);
        runTxn(4'b0001, 4'b0001, 4'b0000, 0, 4, 68);
        runTxn(4'b0001, 4'b0001, 4'b0001, 0, 5, 85);

        $display("[TB] wrap-around search from pointer 3");
        runTxn(4'b0100, 4'b0000, 4'b0100, 2, 4, 68);
        runTxn(4'b0101, 4'b0101, 4'b0100, 0, 4, 68);
        runTxn(4'b1000, 4'b1000, 4'b1000, 3, 5, 85);

        $display("[TB] all four requesting continuously");
        expGntQ.push_back(0); expResQ.push_back('{0, 5, 85});
        expGntQ.push_back(1); expResQ.push_back('{1, 4, 68});
        expGntQ.push_back(2); expResQ.push_back('{2, 4, 68});
        expGntQ.push_back(3); expResQ.push_back('{3, 3, 51});
        expGntQ.push_back(0); expResQ.push_back('{0, 5, 85});
        applyStimulus(4'b1111, 4'b0101, 4'b0011);
        repeat (4) acceptAndCount();
        @(posedge CLK); #1;
        bus.REQ = '0;
        acceptAndCount();

        $display("[TB] back-pressure");
        bus.RES_READY = 1'b0;
        expGntQ.push_back(1);
        expResQ.push_back('{1, 4, 68});
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        @(posedge CLK); #1;
        applyStimulus(4'b0100, 4'b0100, 4'b0100);
        @(posedge CLK); #1;
        repeat (5) begin
            @(negedge CLK);
            checkOutput("stall_valid", 32'(bus.VALID), 1);
            checkOutput("stall_res", 32'(bus.RES), 68);
            checkOutput("stall_res_z", 32'(bus.RES_Z), 4);
            checkOutput("stall_res_id", 32'(bus.RES_ID), 1);
            checkOutput("stall_gnt", 32'(bus.GNT), 0);
        end
        expGntQ.push_back(2);
        expResQ.push_back('{2, 5, 85});
        @(posedge CLK); #1;
        bus.RES_READY = 1'b1;
        acceptAndCount();
        @(posedge CLK); #1;
        checkOutput("gnt_after_accept", 32'(bus.GNT), 32'(4'b0100));
        bus.REQ = '0;
        acceptAndCount();

        $display("[TB] reset during result hold");
        bus.RES_READY = 1'b0;
        expGntQ.push_back(1);
        applyStimulus(4'b0010, 4'b0010, 4'b0010);
        @(posedge CLK); #1;
        bus.REQ = '0;
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("valid_before_reset", 32'(bus.VALID), 1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        checkResetState();
        RST = 1'b0;
        expDone = '0;
        bus.RES_READY = 1'b1;
        runTxn(4'b0101, 4'b0001, 4'b0000, 0, 4, 68);

        $display("[TB] done counter wrap");
        for (int i = 0; i < 255; i++) begin
            case (i % 3)
                0:       runTxn(4'b0001, 4'b0000, 4'b0000, 0, 3, 51);
                1:       runTxn(4'b0001, 4'b0001, 4'b0000, 0, 4, 68);
                default: runTxn(4'b0001, 4'b0001, 4'b0001, 0, 5, 85);
            endcase
        end
        checkOutput("done_wrap", 32'(bus.DONE_CNT), 0);

        checks++;
        if (expGntQ.size() != 0 || expResQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d/%0d expected=0/0",
                     expGntQ.size(), expResQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
